// File: rtl/eeprom_xfer_seq.sv
// Sequences one 24-series EEPROM page write (with ACK polling) or sequential random read
// through a byte-level i2c_master command port, one outstanding command at a time.
module eeprom_xfer_seq #(
  parameter int          NBYTES   = 4,
  parameter logic [6:0]  DEV_ADDR = 7'b1010000,
  parameter logic [15:0] POLL_MAX = 16'd2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                wr_mode,
  input  logic [15:0]         mem_addr,
  input  logic [8*NBYTES-1:0] din,
  output logic [8*NBYTES-1:0] dout,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                m_start,
  output logic [2:0]          m_cmd,
  output logic [7:0]          m_tx,
  input  logic                m_busy,
  input  logic                m_done,
  input  logic [7:0]          m_rx,
  input  logic                m_nack
);

  localparam int W = 8 * NBYTES;

  localparam logic [2:0] CMD_START     = 3'd0;
  localparam logic [2:0] CMD_WRITE     = 3'd1;
  localparam logic [2:0] CMD_READ_ACK  = 3'd2;
  localparam logic [2:0] CMD_READ_NACK = 3'd3;
  localparam logic [2:0] CMD_STOP      = 3'd4;

  localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);

  typedef enum logic [3:0] {
    IDLE, S_START, DEVW, ADRH, ADRL, WDATA, WSTOP, P_START,
    P_DEV, P_STOP, R_START, DEVR, RDATA, RSTOP, ESTOP, FIN
  } state_t;

  state_t        state;
  logic          pending;
  logic          wr_q;
  logic [15:0]   addr_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  shadow;
  logic [3:0]    byte_cnt;
  logic [15:0]   poll_cnt;
  logic          poll_ack;

  logic [2:0]    cur_cmd;
  logic [7:0]    cur_tx;
  logic [15:0]   poll_next;
  logic          last_byte;

  // Command and byte that the current state puts on the master port when it fires.
  always_comb begin
    cur_cmd   = CMD_START;
    cur_tx    = 8'h00;
    last_byte = (byte_cnt == LAST_BYTE);
    poll_next = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
    case (state)
      S_START, P_START, R_START: cur_cmd = CMD_START;
      DEVW, P_DEV: begin
        cur_cmd = CMD_WRITE;
        cur_tx  = {DEV_ADDR, 1'b0};
      end
      ADRH: begin
        cur_cmd = CMD_WRITE;
        cur_tx  = addr_q[15:8];
      end
      ADRL: begin
        cur_cmd = CMD_WRITE;
        cur_tx  = addr_q[7:0];
      end
      WDATA: begin
        cur_cmd = CMD_WRITE;
        cur_tx  = data_q[W-1 -: 8];
      end
      DEVR: begin
        cur_cmd = CMD_WRITE;
        cur_tx  = {DEV_ADDR, 1'b1};
      end
      RDATA: cur_cmd = last_byte ? CMD_READ_NACK : CMD_READ_ACK;
      WSTOP, P_STOP, RSTOP, ESTOP: cur_cmd = CMD_STOP;
      default: cur_cmd = CMD_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0000;
      data_q   <= '0;
      shadow   <= '0;
      dout     <= '0;
      byte_cnt <= 4'd0;
      poll_cnt <= 16'd0;
      poll_ack <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      m_start  <= 1'b0;
      m_cmd    <= 3'd0;
      m_tx     <= 8'h00;
    end else begin
      m_start <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wr_q     <= wr_mode;
            addr_q   <= mem_addr;
            data_q   <= din;
            byte_cnt <= 4'd0;
            poll_cnt <= 16'd0;
            pending  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end
        FIN: state <= IDLE;
        default: begin
          // Each state fires its command once the master is free, then waits for completion.
          if (!pending) begin
            if (!m_busy) begin
              m_start <= 1'b1;
              m_cmd   <= cur_cmd;
              m_tx    <= cur_tx;
              pending <= 1'b1;
            end
          end else if (m_done) begin
            pending <= 1'b0;
            case (state)
              S_START: state <= DEVW;
              DEVW:    state <= m_nack ? ESTOP : ADRH;
              ADRH:    state <= m_nack ? ESTOP : ADRL;
              ADRL: begin
                if (m_nack)    state <= ESTOP;
                else if (wr_q) state <= WDATA;
                else           state <= R_START;
              end
              WDATA: begin
                if (m_nack) begin
                  state <= ESTOP;
                end else begin
                  data_q <= data_q << 8;
                  if (last_byte) state <= WSTOP;
                  else           byte_cnt <= byte_cnt + 4'd1;
                end
              end
              WSTOP:   state <= P_START;
              P_START: state <= P_DEV;
              P_DEV: begin
                poll_ack <= !m_nack;
                state    <= P_STOP;
              end
              P_STOP: begin
                if (poll_ack) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
                end else begin
                  poll_cnt <= poll_next;
                  if (poll_next == POLL_MAX) begin
                    done  <= 1'b1;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= FIN;
                  end else begin
                    state <= P_START;
                  end
                end
              end
              R_START: state <= DEVR;
              DEVR:    state <= m_nack ? ESTOP : RDATA;
              RDATA: begin
                shadow <= (shadow << 8) | W'(m_rx);
                if (last_byte) state <= RSTOP;
                else           byte_cnt <= byte_cnt + 4'd1;
              end
              RSTOP: begin
                dout  <= shadow;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= FIN;
              end
              ESTOP: begin
                done  <= 1'b1;
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= FIN;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_xfer_seq.sv
// Scoreboard bench for eeprom_xfer_seq: a scripted i2c_master/slave model answers each command,
// and a monitor compares every strobe and every done against queued expectations.
module tb_eeprom_xfer_seq;

  localparam logic [2:0] C_START = 3'd0;
  localparam logic [2:0] C_WR    = 3'd1;
  localparam logic [2:0] C_RDA   = 3'd2;
  localparam logic [2:0] C_RDN   = 3'd3;
  localparam logic [2:0] C_STOP  = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, wr_mode, sel;
  logic [15:0] mem_addr;
  logic [31:0] din;
  logic        m_busy, m_done, m_nack;
  logic [7:0]  m_rx;

  logic [31:0] dout_a, dout_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b, m_start_a, m_start_b;
  logic [2:0]  m_cmd_a, m_cmd_b;
  logic [7:0]  m_tx_a, m_tx_b;

  logic        req_a, req_b, m_busy_a, m_busy_b, m_done_a, m_done_b;
  logic        busy_x, done_x, err_x, m_start_x;
  logic [31:0] dout_x;
  logic [2:0]  m_cmd_x;
  logic [7:0]  m_tx_x;

  // sel picks which instance the shared master model serves; the other stays idle.
  assign req_a     = req & ~sel;
  assign req_b     = req & sel;
  assign m_busy_a  = m_busy & ~sel;
  assign m_busy_b  = m_busy & sel;
  assign m_done_a  = m_done & ~sel;
  assign m_done_b  = m_done & sel;
  assign busy_x    = sel ? busy_b : busy_a;
  assign done_x    = sel ? done_b : done_a;
  assign err_x     = sel ? err_b : err_a;
  assign dout_x    = sel ? dout_b : dout_a;
  assign m_start_x = sel ? m_start_b : m_start_a;
  assign m_cmd_x   = sel ? m_cmd_b : m_cmd_a;
  assign m_tx_x    = sel ? m_tx_b : m_tx_a;

  eeprom_xfer_seq #(.NBYTES(4)) dut (
    .clk(clk), .reset(reset), .req(req_a), .wr_mode(wr_mode), .mem_addr(mem_addr), .din(din),
    .dout(dout_a), .busy(busy_a), .done(done_a), .err(err_a),
    .m_start(m_start_a), .m_cmd(m_cmd_a), .m_tx(m_tx_a),
    .m_busy(m_busy_a), .m_done(m_done_a), .m_rx(m_rx), .m_nack(m_nack)
  );

  eeprom_xfer_seq #(.NBYTES(4), .POLL_MAX(16'd3)) dut_p3 (
    .clk(clk), .reset(reset), .req(req_b), .wr_mode(wr_mode), .mem_addr(mem_addr), .din(din),
    .dout(dout_b), .busy(busy_b), .done(done_b), .err(err_b),
    .m_start(m_start_b), .m_cmd(m_cmd_b), .m_tx(m_tx_b),
    .m_busy(m_busy_b), .m_done(m_done_b), .m_rx(m_rx), .m_nack(m_nack)
  );

  logic [10:0] exp_cmd[$];
  logic [8:0]  resp_q[$];
  logic [32:0] exp_done[$];
  int tests_run = 0;
  int tests_failed = 0;
  int lat = 0;
  logic [8:0] cur_resp;

  task automatic check_output(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [7:0] tx, input logic nack, input logic [7:0] rx);
    exp_cmd.push_back({c, tx});
    resp_q.push_back({nack, rx});
  endtask

  task automatic push_hdr(input logic [15:0] addr);
    push_cmd(C_START, 8'h00, 1'b0, 8'h00);
    push_cmd(C_WR, 8'hA0, 1'b0, 8'h00);
    push_cmd(C_WR, addr[15:8], 1'b0, 8'h00);
    push_cmd(C_WR, addr[7:0], 1'b0, 8'h00);
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [31:0] data);
    push_hdr(addr);
    for (int i = 3; i >= 0; i--) push_cmd(C_WR, data[8*i +: 8], 1'b0, 8'h00);
    push_cmd(C_STOP, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic push_poll(input logic nack);
    push_cmd(C_START, 8'h00, 1'b0, 8'h00);
    push_cmd(C_WR, 8'hA0, nack, 8'h00);
    push_cmd(C_STOP, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic push_read(input logic [15:0] addr, input logic [31:0] data);
    push_hdr(addr);
    push_cmd(C_START, 8'h00, 1'b0, 8'h00);
    push_cmd(C_WR, 8'hA1, 1'b0, 8'h00);
    for (int i = 3; i >= 1; i--) push_cmd(C_RDA, 8'h00, 1'b0, data[8*i +: 8]);
    push_cmd(C_RDN, 8'h00, 1'b0, data[7:0]);
    push_cmd(C_STOP, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic apply_stimulus(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_mode  = wr;
    mem_addr = addr;
    din      = data;
    req      = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_x && n < 3000);
    if (!done_x) check_output({name, "_done_timeout"}, 33'd0, 33'd1);
  endtask

  task automatic end_test(input string name);
    @(negedge clk);
    check_output({name, "_cmds_left"}, 33'(exp_cmd.size()), 33'd0);
    check_output({name, "_dones_left"}, 33'(exp_done.size()), 33'd0);
    exp_cmd.delete();
    exp_done.delete();
    resp_q.delete();
  endtask

  // Master + slave model: two cycles of busy per command, then a one-cycle m_done with the scripted reply.
  initial begin
    m_busy = 1'b0;
    m_done = 1'b0;
    m_nack = 1'b0;
    m_rx   = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        lat    = 0;
      end else if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          m_nack = cur_resp[8];
          m_rx   = cur_resp[7:0];
          m_done = 1'b1;
        end
      end else if (m_start_x) begin
        cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 9'h000;
        m_busy   = 1'b1;
        lat      = 2;
      end
    end
  end

  always @(negedge clk) begin
    logic [10:0] ec;
    logic [32:0] ed;
    if (reset && m_start_x) begin
      if (exp_cmd.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_cmd: got cmd %0d tx %0h, expected none", m_cmd_x, m_tx_x);
      end else begin
        ec = exp_cmd.pop_front();
        check_output("m_cmd", 33'(m_cmd_x), 33'(ec[10:8]));
        if (ec[10:8] == C_WR) check_output("m_tx", 33'(m_tx_x), 33'(ec[7:0]));
      end
    end
    if (reset && done_x) begin
      if (exp_done.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_done: got err %0b dout %0h, expected none", err_x, dout_x);
      end else begin
        ed = exp_done.pop_front();
        check_output("done_err", 33'(err_x), 33'(ed[32]));
        check_output("done_dout", 33'(dout_x), 33'(ed[31:0]));
        check_output("done_busy", 33'(busy_x), 33'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; req = 1'b0; wr_mode = 1'b0; sel = 1'b0;
    mem_addr = 16'h0000; din = 32'h0;
    repeat (3) @(negedge clk);
    check_output("rst_busy", 33'(busy_a), 33'd0);
    check_output("rst_done", 33'(done_a), 33'd0);
    check_output("rst_err", 33'(err_a), 33'd0);
    check_output("rst_m_start", 33'(m_start_a), 33'd0);
    check_output("rst_m_cmd", 33'(m_cmd_a), 33'd0);
    check_output("rst_m_tx", 33'(m_tx_a), 33'd0);
    check_output("rst_dout", 33'(dout_a), 33'd0);
    check_output("rst_dout_p3", 33'(dout_b), 33'd0);
    reset = 1'b1;

    // T1: page write, three NACKed polls then an ACK
    push_write(16'h0010, 32'hA1B2C3D4);
    for (int i = 0; i < 4; i++) push_poll(i < 3);
    exp_done.push_back({1'b0, 32'h0});
    apply_stimulus(1'b1, 16'h0010, 32'hA1B2C3D4);
    check_output("t1_busy", 33'(busy_a), 33'd1);
    wait_done("t1");
    end_test("t1");

    // T2: sequential read
    push_read(16'h0010, 32'hA1B2C3D4);
    exp_done.push_back({1'b0, 32'hA1B2C3D4});
    apply_stimulus(1'b0, 16'h0010, 32'h0);
    wait_done("t2");
    end_test("t2");

    // T3: read with NACK on the low address byte; dout must keep the T2 value
    push_cmd(C_START, 8'h00, 1'b0, 8'h00);
    push_cmd(C_WR, 8'hA0, 1'b0, 8'h00);
    push_cmd(C_WR, 8'h01, 1'b0, 8'h00);
    push_cmd(C_WR, 8'h23, 1'b1, 8'h00);
    push_cmd(C_STOP, 8'h00, 1'b0, 8'h00);
    exp_done.push_back({1'b1, 32'hA1B2C3D4});
    apply_stimulus(1'b0, 16'h0123, 32'h0);
    wait_done("t3");
    end_test("t3");

    // T4: POLL_MAX=3 instance, every poll NACKed
    sel = 1'b1;
    push_write(16'h0200, 32'h11223344);
    for (int i = 0; i < 3; i++) push_poll(1'b1);
    exp_done.push_back({1'b1, 32'h0});
    apply_stimulus(1'b1, 16'h0200, 32'h11223344);
    wait_done("t4");
    end_test("t4");
    sel = 1'b0;

    // T5: extra req while busy and in the FIN cycle are both ignored; late din change has no effect
    push_write(16'h0030, 32'h55667788);
    push_poll(1'b0);
    exp_done.push_back({1'b0, 32'hA1B2C3D4});
    apply_stimulus(1'b1, 16'h0030, 32'h55667788);
    repeat (3) @(negedge clk);
    wr_mode = 1'b0; mem_addr = 16'hFFFF; din = 32'hDEADBEEF; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done("t5");
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (30) @(negedge clk);
    check_output("t5_idle_busy", 33'(busy_a), 33'd0);
    end_test("t5");

    // T6: reset during the second data byte, then a clean read
    push_hdr(16'h0040);
    push_cmd(C_WR, 8'h0A, 1'b0, 8'h00);
    push_cmd(C_WR, 8'h0B, 1'b0, 8'h00);
    apply_stimulus(1'b1, 16'h0040, 32'h0A0B0C0D);
    for (int n = 0; n < 500 && exp_cmd.size() > 0; n++) @(negedge clk);
    check_output("t6_reached_byte2", 33'(exp_cmd.size()), 33'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("t6_busy", 33'(busy_a), 33'd0);
    check_output("t6_m_start", 33'(m_start_a), 33'd0);
    check_output("t6_dout", 33'(dout_a), 33'd0);
    reset = 1'b1;
    resp_q.delete();
    push_read(16'h0050, 32'h01020304);
    exp_done.push_back({1'b0, 32'h01020304});
    apply_stimulus(1'b0, 16'h0050, 32'h0);
    wait_done("t6");
    end_test("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
